// File: rtl/alu_iterativa_pkg.sv
// Shared op codes and FSM encoding for the iterative ALU.
package alu_iterativa_pkg;

  // Same sel values the ALU control decoder emits.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOT = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

endpackage

// File: rtl/alu_iterativa_div_restoring.sv
// Iterative unsigned restoring divider, one quotient bit per step.
// The quotient/remainder outputs show the value *after* the current step,
// so the parent can capture the final quotient on the edge of the last step.
module div_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             fin
);

  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out the top, quotient in the bottom
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    r_sh    = {rem_q, quo_q[WIDTH-1]};
    diff    = r_sh - {1'b0, dvs_q};
    ge      = ~diff[WIDTH];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
    // When the trial fails r_sh < divisor, so it fits in WIDTH bits.
    rem_nxt = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  end

  // Next-state: load operands or advance one step.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load) begin
      quo_d = A;
      rem_d = '0;
      dvs_d = B;
    end else if (step) begin
      quo_d = quo_nxt;
      rem_d = rem_nxt;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;
  assign fin       = step & last;

endmodule

// File: rtl/alu_iterativa.sv
// ALU with single-cycle simple ops and iterative MUL (shift-add) / DIV.
// start/busy/done handshake; result, zero and div_zero are registered.
module alu_iterativa
  import alu_iterativa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] acc_nxt;
  logic             cnt_last;
  logic             div_load, div_step, div_fin;
  logic [WIDTH-1:0] div_quo;

  // Single-cycle ops; undefined codes give zero.
  always_comb begin
    simple_res = '0;
    case (sel)
      ALU_ADD: simple_res = A + B;
      ALU_SUB: simple_res = A - B;
      ALU_AND: simple_res = A & B;
      ALU_OR:  simple_res = A | B;
      ALU_XOR: simple_res = A ^ B;
      ALU_NOT: simple_res = ~A;
      ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: simple_res = '0;
    endcase
  end

  // Shift-add partial product for this cycle's multiplier bit.
  always_comb acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign cnt_last = (cnt_q == CNT_LAST);
  assign div_load = (state_q == ST_IDLE) && start && (sel == ALU_DIV) && (B != '0);
  assign div_step = (state_q == ST_DIV);

  div_restoring #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .last      (cnt_last),
    .A         (A),
    .B         (B),
    .quotient  (div_quo),
    .remainder (),
    .fin       (div_fin)
  );

  // FSM next-state, iteration datapath and output register loads.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (sel == ALU_MUL) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else if (sel == ALU_DIV) begin
            if (B == '0) begin
              result_d = '1;
              dz_d     = 1'b1;
              done_d   = 1'b1;
            end else begin
              cnt_d   = '0;
              state_d = ST_DIV;
            end
          end else begin
            result_d = simple_res;
            dz_d     = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_last) begin
          result_d = acc_nxt;
          dz_d     = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (div_fin) begin
          result_d = div_quo;
          dz_d     = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  // State and output registers; reset aborts any iteration immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
